// File: rtl/shift_pkg.sv
// shift_pkg: encodings, FSM states and decode record shared by the shift issue controller.
package shift_pkg;
  localparam logic [1:0] ST_LSL = 2'b00;
  localparam logic [1:0] ST_LSR = 2'b01;
  localparam logic [1:0] ST_ASR = 2'b10;
  localparam logic [2:0] OP_IMM_SHIFT = 3'b000;
  localparam logic [4:0] OP_MOV_IMM = 5'b00100;
  localparam logic [5:0] OP_DP = 6'b010000;
  localparam logic [3:0] OPC_LSL = 4'b0010;
  localparam logic [3:0] OPC_ASR = 4'b0100;
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  typedef enum logic [1:0] {IMM_SHIFT, MOV_IMM, REG_SHIFT, ILLEGAL} cls_t;
  typedef struct packed {
    cls_t cls;
    logic [1:0] stype;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rd;
    logic [7:0] imm;
  } dec_t;
endpackage

// File: rtl/thumb_shift_decode.sv
// thumb_shift_decode: combinational Thumb decode into shift/move class, stype, registers and immediate.
module thumb_shift_decode
  import shift_pkg::*;
(
  input  logic [15:0] inst,
  output dec_t        dec
);
  always_comb begin
    dec = '0;
    dec.cls = ILLEGAL;
    if (inst[15:13] == OP_IMM_SHIFT && inst[12:11] != 2'b11) begin
      dec.cls = IMM_SHIFT;
      dec.stype = inst[12:11];
      dec.ra = inst[5:3];
      dec.rd = inst[2:0];
      // LSR/ASR #0 encodes a full 32-bit shift
      dec.imm = (inst[10:6] == 5'd0 && inst[12:11] != ST_LSL) ? 8'd32 : {3'b000, inst[10:6]};
    end else if (inst[15:11] == OP_MOV_IMM) begin
      dec.cls = MOV_IMM;
      dec.rd = inst[10:8];
      dec.imm = inst[7:0];
    end else if (inst[15:10] == OP_DP && inst[9:6] >= OPC_LSL && inst[9:6] <= OPC_ASR) begin
      dec.cls = REG_SHIFT;
      dec.stype = 2'(inst[9:6] - OPC_LSL);
      dec.ra = inst[2:0];
      dec.rb = inst[5:3];
      dec.rd = inst[2:0];
    end
  end
endmodule

// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl: four-state issue FSM feeding the shift unit and owning the NZC flags.
module shift_issue_ctrl
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [15:0] inst,
  output logic [2:0]  rf_raddr_a,
  output logic [2:0]  rf_raddr_b,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  output logic        sh_en,
  output logic        sh_s,
  output logic [31:0] sh_rm,
  output logic [7:0]  sh_operand2,
  output logic [1:0]  sh_stype,
  output logic        sh_carry_in,
  output logic        sh_zero_in,
  output logic        sh_neg_in,
  input  logic [31:0] sh_rd,
  input  logic        sh_carry_out,
  input  logic        sh_zero_out,
  input  logic        sh_neg_out,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        done,
  output logic        illegal
);
  state_t state, nxt;
  dec_t d, q;
  logic unused_rdata_b;
  assign unused_rdata_b = ^rf_rdata_b[31:8];
  thumb_shift_decode u_dec (.inst(inst), .dec(d));
  always_comb begin
    nxt = state == IDLE ? ((inst_valid && d.cls != ILLEGAL) ? READ : IDLE) :
          state == READ ? EXEC : state == EXEC ? WB : IDLE;
    inst_ready = state == IDLE;
    sh_en = state == EXEC;
    rf_we = state == WB;
    done = state == WB;
    rf_raddr_a = q.ra;
    rf_raddr_b = q.rb;
    sh_carry_in = flag_c;
    sh_zero_in = flag_z;
    sh_neg_in = flag_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q <= '0;
      illegal <= 1'b0;
      sh_s <= 1'b0;
      sh_rm <= '0;
      sh_operand2 <= '0;
      sh_stype <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= nxt;
      illegal <= state == IDLE && inst_valid && d.cls == ILLEGAL;
      if (state == IDLE && inst_valid) q <= d;
      if (state == READ) begin
        sh_s <= 1'b1;
        sh_stype <= q.stype;
        sh_rm <= q.cls == MOV_IMM ? {24'd0, q.imm} : rf_rdata_a;
        sh_operand2 <= q.cls == REG_SHIFT ? rf_rdata_b[7:0] : (q.cls == MOV_IMM ? 8'd0 : q.imm);
      end
      // flags land with the captured result so they are visible alongside rf_we
      if (state == EXEC) begin
        rf_waddr <= q.rd;
        rf_wdata <= sh_rd;
        flag_n <= sh_neg_out;
        flag_z <= sh_zero_out;
        flag_c <= q.cls == MOV_IMM ? flag_c : sh_carry_out;
      end
    end
  end
endmodule

// File: doc/shift_issue_ctrl.md
# shift_issue_ctrl

Issue controller that drives the mov/logic/arith shift unit from 16-bit Thumb instructions. It accepts one instruction per valid/ready handshake, decodes the shift and move class, reads operands from the register file, and issues one operation to the shift unit. It then writes the result and the N/Z/C flags back. The block owns the NZC flag state that the shift unit consumes as `*_in` and returns as `*_out`.

## Interface
Parameters: none. Encodings and constants live in `shift_pkg`.

- `clk` in 1: single clock. All state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `inst_valid` in 1: `inst` is valid.
- `inst_ready` out 1: block can accept an instruction (IDLE only).
- `inst` in 16: Thumb instruction.
- `rf_raddr_a` out 3: source register (Rm, or Rdn for register shifts).
- `rf_raddr_b` out 3: shift-amount register (Rs).
- `rf_rdata_a` in 32: combinational read data for port A.
- `rf_rdata_b` in 32: combinational read data for port B.
- `sh_en` out 1: shift unit `en_inst`.
- `sh_s` out 1: shift unit `S`. Always 1 for accepted legal ops.
- `sh_rm` out 32: shift unit `Rm`.
- `sh_operand2` out 8: shift amount.
- `sh_stype` out 2: 00 = LSL, 01 = LSR, 10 = ASR.
- `sh_carry_in`, `sh_zero_in`, `sh_neg_in` out 1 each: current flags.
- `sh_rd` in 32: shift unit result.
- `sh_carry_out`, `sh_zero_out`, `sh_neg_out` in 1 each: flags returned by the shift unit.
- `rf_we` out 1: register write strobe.
- `rf_waddr` out 3: write address.
- `rf_wdata` out 32: write data.
- `flag_n`, `flag_z`, `flag_c` out 1 each: architectural flags.
- `done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse when an instruction is rejected.

## Operation
Decoded classes:
- **Immediate shift** `000 op[1:0] imm5 Rm Rd`, with op 00/01/10 = LSL/LSR/ASR.
  - `sh_rm` = R[Rm], `sh_operand2` = {3'b0, imm5}.
  - For LSR/ASR, imm5 = 0 encodes a shift of 32 (`sh_operand2` = 8'd32).
  - op = 11 is not in this class.
- **MOVS immediate** `00100 Rd imm8`.
  - `sh_rm` = {24'b0, imm8}, `sh_stype` = LSL, `sh_operand2` = 0.
  - C is written back with its previous value. The block forces C = old C regardless of `sh_carry_out`.
- **Register shift** `010000 opc[3:0] Rs Rdn`, with opc 0010/0011/0100 = LSL/LSR/ASR.
  - `sh_rm` = R[Rdn], `sh_operand2` = R[Rs][7:0], destination = Rdn.
- **Anything else** is illegal: no register write, no flag change, `illegal` pulses.

FSM states: IDLE, READ, EXEC, WB.
- **IDLE**: `inst_ready` = 1.
  - On `inst_valid`, latch `inst` and the decode result.
  - Legal → READ. Illegal → IDLE with `illegal` = 1 for the next cycle.
- **READ**: drive `rf_raddr_a/b`. Register the operand, amount and stype into the `sh_*` output registers. → EXEC.
- **EXEC**: `sh_en` = 1. The shift unit evaluates on the negedge inside this cycle. At the posedge that ends EXEC, capture `sh_rd` and the flags. → WB.
- **WB**: `rf_we` = 1 with the captured data. Flag registers update. `done` = 1. → IDLE.

## Timing
- Legal instruction: accepted at edge T. `rf_we`, `done` and the new flags are visible during cycle T+3.
- Throughput: one instruction per 4 cycles. The earliest next accept is at edge T+4.
- Illegal instruction: `illegal` is high in cycle T+1, and `inst_ready` stays 1.
- `sh_en` is high for exactly one cycle per legal instruction and is never high for illegal ones.
- `inst` is ignored while `inst_ready` = 0. A held `inst_valid` is treated as a new request only once IDLE is re-entered.
- Reset values: state = IDLE, `inst_ready` = 1 (combinational from state).
  - All of the following are 0: `sh_en`, `sh_s`, `sh_rm`, `sh_operand2`, `sh_stype`, `rf_we`, `rf_waddr`, `rf_wdata`, `done`, `illegal`, all flags.
- Reset mid-operation, in any state: return to IDLE immediately. The in-flight instruction is discarded, with no `rf_we` and no flag change.
- Register shift with R[Rs] ≥ 256: only bits [7:0] are passed to the shift unit.
- Source equal to destination is legal: the operand is read in READ, before the write in WB.

## Structure
- `shift_pkg`: stype constants (`ST_LSL` = 2'b00, `ST_LSR` = 2'b01, `ST_ASR` = 2'b10), FSM state enum, opcode field constants, and the class enum (IMM_SHIFT, MOV_IMM, REG_SHIFT, ILLEGAL).
- Sub-module `thumb_shift_decode`: purely combinational decode from `inst` to class, stype, register fields and immediate.
- `shift_issue_ctrl` holds the FSM, the latches and the flag registers.

## Test plan
- Reset, then `inst` = LSLS R1,R0,#4 (0x0101) with R0 = 0x0000_00F1.
  - → `rf_we` at T+3, `rf_waddr` = 1, `rf_wdata` = 0x0000_0F10, N = 0, Z = 0, `done` pulse.
- ASRS R2,R3,#0 (0x101A) with R3 = 0x8000_0000.
  - → `sh_operand2` = 32, `sh_stype` = 10, result written to R2 per the shift unit, N = 1.
- MOVS R5,#0 (0x2500) with C = 1 beforehand.
  - → `rf_wdata` = 0, Z = 1, N = 0, C stays 1.
- LSRS R4,R6 (0x40F4) with R6 = 0x0000_0103, R4 = 0x10.
  - → `sh_operand2` = 0x03, `sh_rm` = 0x10, destination 4.
- Illegal 0xBF00 (NOP).
  - → `illegal` pulse at T+1, no `sh_en`, no `rf_we`, flags unchanged. A legal instruction is accepted in the next cycle.
- Assert `rst` during EXEC.
  - → all outputs at reset values, no `rf_we`. A subsequent instruction executes normally.
